cpu_alu_decode: RTL and testbench
=================================

Name: cpu_alu_decode

Overview:
- Combined execution helper for the 8-bit Z80-style CPU core.
- Combinational instruction field splitter: x/y/z fields per the z80.info decoding scheme.
- 8-bit ALU with one-cycle registered result plus a persistent flag register.
- Condition-code evaluator that reads the stored flags; the CPU state machine uses it for JP cc,nn.

Parameters:
- WIDTH, 8, ALU data width. Only 8 is required to be supported.

Ports:
- clk  input  1  system clock, rising-edge active
- rst  input  1  reset, asynchronous, active-high
- insn  input  8  current instruction byte
- insn_x  output  2  insn[7:6], combinational
- insn_y  output  3  insn[5:3], combinational
- insn_z  output  3  insn[2:0], combinational
- alu_valid  input  1  launch ALU operation this cycle
- operator  input  3  ALU operation select
- operand_a  input  8  first operand
- operand_b  input  8  second operand
- carry_in  input  1  external carry, used by ADC/SBC
- result  output  8  registered ALU result
- result_valid  output  1  one-cycle pulse, result updated
- flag_zero  output  1  stored Z flag
- flag_carry  output  1  stored C flag
- cc_true  output  1  condition cc[insn_y] evaluated on stored flags

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high.
- Reset values: result=0x00, result_valid=0, flag_zero=0, flag_carry=0.
- Reset mid-operation: an in-flight operation is discarded, and alu_valid is ignored while rst is high.
- Decode is purely combinational, with no clock dependency: x=insn[7:6], y=insn[5:3], z=insn[2:0].
- Operator encoding, with c = carry_in:
  - 0 NOP: result = a; flags unchanged.
  - 1 ADD: a+b.
  - 2 ADC: a+b+c.
  - 3 SUB: a-b.
  - 4 SBC: a-b-c.
  - 5 AND: a&b.
  - 6 XOR: a^b.
  - 7 OR: a|b.
- Arithmetic uses a 9-bit intermediate; result is the low 8 bits, modulo 256 (wrap-around).
- Carry flag:
  - ADD/ADC: bit 8 of the sum.
  - SUB/SBC: borrow, set when a < b + c (unsigned, 9-bit compare).
  - AND/XOR/OR: cleared.
- Zero flag: set when the 8-bit result == 0, for every operator except NOP.
- Latency: operands are sampled on the clk edge where alu_valid=1. result, the flags and result_valid=1 appear after that edge.
- result_valid falls the next cycle unless alu_valid is held. Back-to-back operations are accepted every cycle.
- When alu_valid=0, result and the flags hold their values.
- NOP with alu_valid=1 updates result and pulses result_valid but leaves the flags unchanged.
- cc_true is combinational from insn_y and the stored flags:
  - y=0 NZ → !flag_zero
  - y=1 Z → flag_zero
  - y=2 NC → !flag_carry
  - y=3 C → flag_carry
  - y=4..7 → 0
- Simultaneous launch and cc read: cc_true reflects the flags before the launching edge. New flags are visible only after that edge.

Optional Feature:
- Macro ALU_HALF_CARRY_EN.
- When defined:
  - Adds output flag_half (1 bit), reset 0.
  - ADD/ADC set it on carry out of bit 3. SUB/SBC set it on borrow from bit 4.
  - AND sets it to 1. XOR and OR clear it. NOP leaves it unchanged.
  - It updates on the same edge as the other flags.
  - cc_true is unaffected.
- When undefined: the port and its register are absent; all other behaviour is identical.

Test Plan:
- Decode: insn=0xC2 → x=3, y=0, z=2; insn=0x3E → x=0, y=7, z=6; insn=0x78 → x=1, y=7, z=0.
- ADD 0xFF+0x01 (alu_valid pulse) → next cycle result=0x00, Z=1, C=1, result_valid=1 for one cycle. With insn=0xCA (y=1), cc_true=1; with y=0, cc_true=0.
- SUB 0x05-0x06 → result=0xFF, Z=0, C=1. Then SBC 0x10-0x0F with carry_in=1 → result=0x00, Z=1, C=0.
- Logic ops: AND 0xF0&0x3C → 0x30, C=0; XOR 0xAA^0xAA → 0x00, Z=1; OR 0x00|0x00 → Z=1. Then NOP a=0x42 → result=0x42 with flags unchanged (Z=1).
- Flag hold: set C=1 via ADD 0x80+0x80; idle 5 cycles with alu_valid=0 → C stays 1, and cc_true=1 for y=3. Assert rst mid-idle → result=0, flags=0, result_valid=0 immediately, without waiting for a clock edge.
- With ALU_HALF_CARRY_EN defined: ADD 0x0F+0x01 → result=0x10, flag_half=1; SUB 0x10-0x01 → result=0x0F, flag_half=1.

Source files
------------

// File: rtl/cpu_alu_decode.sv
// Z80-style execution helper: insn x/y/z field split, 8-bit ALU with registered result and flags,
// and condition-code evaluation on the stored flags. Optional half-carry flag: ALU_HALF_CARRY_EN.
module cpu_alu_decode #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       insn,
    output logic [1:0]       insn_x,
    output logic [2:0]       insn_y,
    output logic [2:0]       insn_z,
    input  logic             alu_valid,
    input  logic [2:0]       operator,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic             carry_in,
    output logic [WIDTH-1:0] result,
    output logic             result_valid,
    output logic             flag_zero,
    output logic             flag_carry,
`ifdef ALU_HALF_CARRY_EN
    output logic             flag_half,
`endif
    output logic             cc_true
);

    localparam logic [2:0] OpNop = 3'd0;
    localparam logic [2:0] OpAdd = 3'd1;
    localparam logic [2:0] OpAdc = 3'd2;
    localparam logic [2:0] OpSub = 3'd3;
    localparam logic [2:0] OpSbc = 3'd4;
    localparam logic [2:0] OpAnd = 3'd5;
    localparam logic [2:0] OpXor = 3'd6;
    localparam logic [2:0] OpOr  = 3'd7;

    logic [WIDTH-1:0] result_q, result_d;
    logic             valid_q;
    logic             zero_q, zero_d;
    logic             carry_q, carry_d;
    logic             upd_flags;
    logic [WIDTH:0]   a_ext, b_ext, c_ext, sum_ext;

    assign insn_x = insn[7:6];
    assign insn_y = insn[5:3];
    assign insn_z = insn[2:0];

    assign a_ext = {1'b0, operand_a};
    assign b_ext = {1'b0, operand_b};
    assign c_ext = {{WIDTH{1'b0}}, carry_in};

    always_comb begin
        result_d  = operand_a;
        carry_d   = carry_q;
        upd_flags = 1'b1;
        sum_ext   = '0;
        case (operator)
            OpNop: upd_flags = 1'b0;
            OpAdd: begin
                sum_ext  = a_ext + b_ext;
                result_d = sum_ext[WIDTH-1:0];
                carry_d  = sum_ext[WIDTH];
            end
            OpAdc: begin
                sum_ext  = a_ext + b_ext + c_ext;
                result_d = sum_ext[WIDTH-1:0];
                carry_d  = sum_ext[WIDTH];
            end
            OpSub: begin
                sum_ext  = a_ext - b_ext;
                result_d = sum_ext[WIDTH-1:0];
                carry_d  = (a_ext < b_ext);
            end
            OpSbc: begin
                sum_ext  = a_ext - b_ext - c_ext;
                result_d = sum_ext[WIDTH-1:0];
                // b + c fits in WIDTH+1 bits, so the borrow compare is exact
                carry_d  = (a_ext < (b_ext + c_ext));
            end
            OpAnd: begin
                result_d = operand_a & operand_b;
                carry_d  = 1'b0;
            end
            OpXor: begin
                result_d = operand_a ^ operand_b;
                carry_d  = 1'b0;
            end
            OpOr: begin
                result_d = operand_a | operand_b;
                carry_d  = 1'b0;
            end
            default: upd_flags = 1'b0;
        endcase
        zero_d = (result_d == '0);
    end

`ifdef ALU_HALF_CARRY_EN
    logic       half_q, half_d;
    logic [4:0] a_nib, b_nib, c_nib, nib_sum;

    assign a_nib = {1'b0, operand_a[3:0]};
    assign b_nib = {1'b0, operand_b[3:0]};
    assign c_nib = {4'b0, carry_in};

    always_comb begin
        half_d  = half_q;
        nib_sum = '0;
        case (operator)
            OpAdd: begin
                nib_sum = a_nib + b_nib;
                half_d  = nib_sum[4];
            end
            OpAdc: begin
                nib_sum = a_nib + b_nib + c_nib;
                half_d  = nib_sum[4];
            end
            OpSub:   half_d = (a_nib < b_nib);
            OpSbc:   half_d = (a_nib < (b_nib + c_nib));
            OpAnd:   half_d = 1'b1;
            OpXor:   half_d = 1'b0;
            OpOr:    half_d = 1'b0;
            default: half_d = half_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            half_q <= 1'b0;
        end else if (alu_valid && upd_flags) begin
            half_q <= half_d;
        end
    end

    assign flag_half = half_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_q <= '0;
            valid_q  <= 1'b0;
            zero_q   <= 1'b0;
            carry_q  <= 1'b0;
        end else begin
            valid_q <= alu_valid;
            if (alu_valid) begin
                result_q <= result_d;
                if (upd_flags) begin
                    zero_q  <= zero_d;
                    carry_q <= carry_d;
                end
            end
        end
    end

    assign result       = result_q;
    assign result_valid = valid_q;
    assign flag_zero    = zero_q;
    assign flag_carry   = carry_q;

    always_comb begin
        case (insn_y)
            3'd0:    cc_true = ~zero_q;
            3'd1:    cc_true = zero_q;
            3'd2:    cc_true = ~carry_q;
            3'd3:    cc_true = carry_q;
            default: cc_true = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_cpu_alu_decode.sv
// Directed self-checking bench for cpu_alu_decode; half-carry checks build with ALU_HALF_CARRY_EN.
module tb_cpu_alu_decode;

    logic       clk;
    logic       rst;
    logic [7:0] insn;
    logic [1:0] insn_x;
    logic [2:0] insn_y;
    logic [2:0] insn_z;
    logic       alu_valid;
    logic [2:0] operator;
    logic [7:0] operand_a;
    logic [7:0] operand_b;
    logic       carry_in;
    logic [7:0] result;
    logic       result_valid;
    logic       flag_zero;
    logic       flag_carry;
    logic       cc_true;
`ifdef ALU_HALF_CARRY_EN
    logic       flag_half;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    cpu_alu_decode #(.WIDTH(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .insn         (insn),
        .insn_x       (insn_x),
        .insn_y       (insn_y),
        .insn_z       (insn_z),
        .alu_valid    (alu_valid),
        .operator     (operator),
        .operand_a    (operand_a),
        .operand_b    (operand_b),
        .carry_in     (carry_in),
        .result       (result),
        .result_valid (result_valid),
        .flag_zero    (flag_zero),
        .flag_carry   (flag_carry),
`ifdef ALU_HALF_CARRY_EN
        .flag_half    (flag_half),
`endif
        .cc_true      (cc_true)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one op for a single edge; returns at the following negedge with the result visible.
    task automatic launch(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                          input logic c);
        @(negedge clk);
        alu_valid = 1'b1;
        operator  = op;
        operand_a = a;
        operand_b = b;
        carry_in  = c;
        @(negedge clk);
        alu_valid = 1'b0;
    endtask

    initial begin
        rst       = 1'b0;
        insn      = 8'h00;
        alu_valid = 1'b0;
        operator  = 3'd0;
        operand_a = 8'h00;
        operand_b = 8'h00;
        carry_in  = 1'b0;
        #1 rst = 1'b1;
        #1;
        check("rst_result", result, 8'h00);
        check("rst_valid", result_valid, 1'b0);
        check("rst_zero", flag_zero, 1'b0);
        check("rst_carry", flag_carry, 1'b0);
        // Launch while in reset must be discarded
        alu_valid = 1'b1;
        operator  = 3'd1;
        operand_a = 8'h11;
        operand_b = 8'h22;
        repeat (2) @(negedge clk);
        check("rst_launch_result", result, 8'h00);
        check("rst_launch_valid", result_valid, 1'b0);
        alu_valid = 1'b0;
        rst       = 1'b0;

        insn = 8'hC2; #1;
        check("dec_c2_x", insn_x, 2'd3);
        check("dec_c2_y", insn_y, 3'd0);
        check("dec_c2_z", insn_z, 3'd2);
        insn = 8'h3E; #1;
        check("dec_3e_x", insn_x, 2'd0);
        check("dec_3e_y", insn_y, 3'd7);
        check("dec_3e_z", insn_z, 3'd6);
        insn = 8'h78; #1;
        check("dec_78_x", insn_x, 2'd1);
        check("dec_78_y", insn_y, 3'd7);
        check("dec_78_z", insn_z, 3'd0);
        check("cc_y7", cc_true, 1'b0);

        launch(3'd1, 8'hFF, 8'h01, 1'b0);
        check("add_ff_result", result, 8'h00);
        check("add_ff_valid", result_valid, 1'b1);
        check("add_ff_zero", flag_zero, 1'b1);
        check("add_ff_carry", flag_carry, 1'b1);
        insn = 8'hCA; #1;
        check("cc_z", cc_true, 1'b1);
        insn = 8'hC2; #1;
        check("cc_nz", cc_true, 1'b0);
        @(negedge clk);
        check("valid_pulse_drop", result_valid, 1'b0);
        check("hold_result", result, 8'h00);

        launch(3'd3, 8'h05, 8'h06, 1'b0);
        check("sub_result", result, 8'hFF);
        check("sub_zero", flag_zero, 1'b0);
        check("sub_carry", flag_carry, 1'b1);
        insn = 8'hDA; #1;
        check("cc_c", cc_true, 1'b1);
        insn = 8'hD2; #1;
        check("cc_nc", cc_true, 1'b0);

        launch(3'd4, 8'h10, 8'h0F, 1'b1);
        check("sbc_result", result, 8'h00);
        check("sbc_zero", flag_zero, 1'b1);
        check("sbc_carry", flag_carry, 1'b0);
        check("cc_nc_after_sbc", cc_true, 1'b1);

        launch(3'd4, 8'h00, 8'hFF, 1'b1);
        check("sbc_wrap_result", result, 8'h00);
        check("sbc_wrap_carry", flag_carry, 1'b1);

        launch(3'd2, 8'hFF, 8'h00, 1'b1);
        check("adc_result", result, 8'h00);
        check("adc_carry", flag_carry, 1'b1);
        launch(3'd1, 8'h01, 8'h01, 1'b1);
        check("add_ignores_cin", result, 8'h02);
        check("add_small_carry", flag_carry, 1'b0);
        check("add_small_zero", flag_zero, 1'b0);

        // Back-to-back: two consecutive launch edges
        @(negedge clk);
        alu_valid = 1'b1; operator = 3'd2; operand_a = 8'h01; operand_b = 8'h01; carry_in = 1'b1;
        @(negedge clk);
        check("b2b_first", result, 8'h03);
        check("b2b_first_valid", result_valid, 1'b1);
        operator = 3'd1; operand_a = 8'h10; operand_b = 8'h20; carry_in = 1'b0;
        @(negedge clk);
        alu_valid = 1'b0;
        check("b2b_second", result, 8'h30);
        check("b2b_second_valid", result_valid, 1'b1);

        launch(3'd5, 8'hF0, 8'h3C, 1'b1);
        check("and_result", result, 8'h30);
        check("and_carry", flag_carry, 1'b0);
        check("and_zero", flag_zero, 1'b0);
        launch(3'd6, 8'hAA, 8'hAA, 1'b0);
        check("xor_result", result, 8'h00);
        check("xor_zero", flag_zero, 1'b1);
        launch(3'd7, 8'h00, 8'h00, 1'b0);
        check("or_zero", flag_zero, 1'b1);
        launch(3'd7, 8'h81, 8'h02, 1'b0);
        check("or_result", result, 8'h83);
        check("or_nz", flag_zero, 1'b0);
        launch(3'd7, 8'h00, 8'h00, 1'b0);
        launch(3'd0, 8'h42, 8'hFF, 1'b1);
        check("nop_result", result, 8'h42);
        check("nop_valid", result_valid, 1'b1);
        check("nop_zero_kept", flag_zero, 1'b1);
        check("nop_carry_kept", flag_carry, 1'b0);

        // cc_true must show pre-edge flags during the launching cycle
        @(negedge clk);
        insn = 8'hDA;
        alu_valid = 1'b1; operator = 3'd1; operand_a = 8'h80; operand_b = 8'h81; carry_in = 1'b0;
        #1;
        check("cc_before_edge", cc_true, 1'b0);
        @(negedge clk);
        alu_valid = 1'b0;
        check("cc_after_edge", cc_true, 1'b1);
        check("add80_result", result, 8'h01);
        check("add80_carry", flag_carry, 1'b1);
        check("add80_zero", flag_zero, 1'b0);
        repeat (5) @(negedge clk);
        check("idle_carry", flag_carry, 1'b1);
        check("idle_result", result, 8'h01);
        check("idle_valid", result_valid, 1'b0);
        check("idle_cc", cc_true, 1'b1);

        #2 rst = 1'b1;
        #1;
        check("async_rst_result", result, 8'h00);
        check("async_rst_carry", flag_carry, 1'b0);
        check("async_rst_zero", flag_zero, 1'b0);
        check("async_rst_valid", result_valid, 1'b0);
        @(negedge clk);
        rst = 1'b0;

`ifdef ALU_HALF_CARRY_EN
        check("half_rst", flag_half, 1'b0);
        launch(3'd1, 8'h0F, 8'h01, 1'b0);
        check("half_add_result", result, 8'h10);
        check("half_add", flag_half, 1'b1);
        launch(3'd3, 8'h10, 8'h01, 1'b0);
        check("half_sub_result", result, 8'h0F);
        check("half_sub", flag_half, 1'b1);
        launch(3'd6, 8'h01, 8'h01, 1'b0);
        check("half_xor", flag_half, 1'b0);
        launch(3'd5, 8'h01, 8'h01, 1'b0);
        check("half_and", flag_half, 1'b1);
        launch(3'd0, 8'h00, 8'h00, 1'b0);
        check("half_nop_kept", flag_half, 1'b1);
        launch(3'd2, 8'h07, 8'h08, 1'b1);
        check("half_adc", flag_half, 1'b1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
